clint_rtc_gen: RTL and testbench

// - Fractional (NCO) real-time tick source that derives the CLINT rtc_i input from the system clock.
// - Produces a glitch-free square wave of constant frequency: f_rtc = f_clk * inc / 2^AccWidth.
//   The CLINT synchronises it and increments mtime on each rising edge.
// - Frequency reprogramming uses a valid/ready handshake. A new value takes effect only at a

---
 rtl/clint_rtc_gen.sv | 128 ++++++++++++
 tb/tb_clint_rtc_gen.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clint_rtc_gen.sv
// NCO real-time tick source for the CLINT: f_rtc = f_clk * inc / 2^AccWidth.
// Optional rising-edge counter on tick_cnt_o when CLINT_RTC_GEN_TICK_CNT_EN is defined.
module clint_rtc_gen #(
  parameter int unsigned AccWidth = 32,
  parameter int unsigned MaxInc   = 2**(AccWidth-2),
  parameter int unsigned ResetInc = 0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic [AccWidth-1:0] inc_i,
  input  logic                inc_valid_i,
  output logic                inc_ready_o,
  output logic                rtc_o,
  output logic                tick_o,
  output logic                busy_o
`ifdef CLINT_RTC_GEN_TICK_CNT_EN
  ,
  output logic [31:0]         tick_cnt_o
`endif
);

  localparam int unsigned W = AccWidth;
  localparam logic [W-1:0] MaxIncW = W'(MaxInc);
  localparam logic [W-1:0] RstIncW =
    (ResetInc > MaxInc) ? W'(MaxInc) : W'(ResetInc);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   acc_q, acc_nxt;
  logic [W-1:0]   inc_q, pend_q;
  logic           pend_vld_q;
  logic           msb_q;
  logic [W-1:0]   step;
  logic [W-1:0]   inc_eff;
  logic [W:0]     sum;
  logic           wrap;
  logic           apply;
  logic           stop;

  // A zero increment while draining must still finish the high phase.
  assign step = (state_q == DRAIN && inc_q == '0) ? MaxIncW : inc_q;
  assign sum  = {1'b0, acc_q} + {1'b0, step};
  assign wrap = sum[W];

  assign inc_eff     = (inc_i > MaxIncW) ? MaxIncW : inc_i;
  assign inc_ready_o = !pend_vld_q;
  assign apply       = pend_vld_q & ((state_q == IDLE) | wrap);
  assign stop        = !en_i || inc_q == '0;

  assign rtc_o  = acc_q[W-1];
  assign tick_o = acc_q[W-1] & ~msb_q;
  assign busy_o = state_q != IDLE;

  always_comb begin
    state_d = state_q;
    acc_nxt = acc_q;
    unique case (state_q)
      IDLE: begin
        acc_nxt = '0;
        if (en_i && inc_q != '0) state_d = RUN;
      end
      RUN: begin
        acc_nxt = sum[W-1:0];
        if (stop) begin
          // A wrap here already ends the high phase.
          if (acc_q[W-1] && !wrap) begin
            state_d = DRAIN;
          end else begin
            state_d = IDLE;
            acc_nxt = '0;
          end
        end
      end
      DRAIN: begin
        acc_nxt = sum[W-1:0];
        if (en_i && inc_q != '0) begin
          state_d = RUN;
        end else if (wrap) begin
          state_d = IDLE;
          acc_nxt = '0;
        end
      end
      default: begin
        state_d = IDLE;
        acc_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      msb_q      <= 1'b0;
      inc_q      <= RstIncW;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_nxt;
      msb_q   <= acc_q[W-1];
      if (apply) begin
        inc_q      <= pend_q;
        pend_vld_q <= 1'b0;
      end else if (inc_valid_i && inc_ready_o) begin
        pend_q     <= inc_eff;
        pend_vld_q <= 1'b1;
      end
    end
  end

`ifdef CLINT_RTC_GEN_TICK_CNT_EN
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      tick_cnt_o <= '0;
    end else if (tick_o) begin
      tick_cnt_o <= tick_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_clint_rtc_gen.sv
// Directed bench for clint_rtc_gen with AccWidth=8 (MaxInc=64).
// Table-driven vectors plus hand sequences for drain, handshake, jitter, reset.
module tb_clint_rtc_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] inc;
  logic       inc_valid;
  logic       inc_ready;
  logic       rtc;
  logic       tick;
  logic       busy;
`ifdef CLINT_RTC_GEN_TICK_CNT_EN
  logic [31:0] tick_cnt;
`endif

  int tests = 0;
  int fails = 0;
  int nticks = 0;

  always #5 clk = ~clk;

  clint_rtc_gen #(
    .AccWidth(8)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .en_i       (en),
    .inc_i      (inc),
    .inc_valid_i(inc_valid),
    .inc_ready_o(inc_ready),
    .rtc_o      (rtc),
    .tick_o     (tick),
    .busy_o     (busy)
`ifdef CLINT_RTC_GEN_TICK_CNT_EN
    ,
    .tick_cnt_o (tick_cnt)
`endif
  );

  typedef struct {
    logic       en;
    logic       vld;
    logic [7:0] inc;
    logic       rtc;
    logic       tick;
    logic       rdy;
    logic       busy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic e, logic v, logic [7:0] i,
                              logic r, logic t, logic rd, logic b);
    vec_t x;
    x.en = e; x.vld = v; x.inc = i;
    x.rtc = r; x.tick = t; x.rdy = rd; x.busy = b;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (tick === 1'b1) nticks++;
  endtask

  initial begin
    int high;
    int lowcnt;
    int last;
    int gmin;
    int gmax;
    int t0;
    bit seen;

    tbl.push_back(mk(0, 1,  64, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0,   0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0,   0, 0, 0, 1, 1));
    tbl.push_back(mk(1, 0,   0, 0, 0, 1, 1));
    tbl.push_back(mk(1, 0,   0, 1, 1, 1, 1));
    tbl.push_back(mk(1, 0,   0, 1, 0, 1, 1));
    tbl.push_back(mk(1, 0,   0, 0, 0, 1, 1));
    tbl.push_back(mk(1, 0,   0, 0, 0, 1, 1));
    tbl.push_back(mk(1, 0,   0, 1, 1, 1, 1));
    tbl.push_back(mk(1, 0,   0, 1, 0, 1, 1));
    tbl.push_back(mk(1, 1, 200, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0,   0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0,   0, 1, 1, 0, 1));
    tbl.push_back(mk(1, 0,   0, 1, 0, 0, 1));
    tbl.push_back(mk(1, 0,   0, 0, 0, 1, 1));
    tbl.push_back(mk(1, 1,  32, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0,   0, 1, 1, 0, 1));
    tbl.push_back(mk(1, 0,   0, 1, 0, 0, 1));
    tbl.push_back(mk(1, 0,   0, 0, 0, 1, 1));
    tbl.push_back(mk(1, 0,   0, 0, 0, 1, 1));
    tbl.push_back(mk(1, 0,   0, 0, 0, 1, 1));
    tbl.push_back(mk(1, 0,   0, 0, 0, 1, 1));
    tbl.push_back(mk(1, 0,   0, 1, 1, 1, 1));
    tbl.push_back(mk(1, 0,   0, 1, 0, 1, 1));
    tbl.push_back(mk(1, 0,   0, 1, 0, 1, 1));
    tbl.push_back(mk(1, 0,   0, 1, 0, 1, 1));
    tbl.push_back(mk(1, 0,   0, 0, 0, 1, 1));
    tbl.push_back(mk(1, 0,   0, 0, 0, 1, 1));
    tbl.push_back(mk(1, 1,  16, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0,   0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0,   0, 1, 1, 0, 1));
    tbl.push_back(mk(1, 0,   0, 1, 0, 0, 1));
    tbl.push_back(mk(1, 0,   0, 1, 0, 0, 1));
    tbl.push_back(mk(1, 0,   0, 1, 0, 0, 1));
    tbl.push_back(mk(1, 0,   0, 0, 0, 1, 1));

    rst_n = 1'b0;
    en = 1'b0;
    inc = '0;
    inc_valid = 1'b0;
    step();
    step();
    nticks = 0;
    check("reset", {rtc, tick, inc_ready, busy}, 4'b0010);
`ifdef CLINT_RTC_GEN_TICK_CNT_EN
    check("reset_cnt", tick_cnt, 32'd0);
`endif
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      en = tbl[i].en;
      inc_valid = tbl[i].vld;
      inc = tbl[i].inc;
      step();
      check($sformatf("vec%0d", i), {rtc, tick, inc_ready, busy},
            {tbl[i].rtc, tbl[i].tick, tbl[i].rdy, tbl[i].busy});
    end

    // inc=16: drop en two cycles into the high phase
    en = 1'b1;
    inc_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      step();
      seen = tick;
    end
    check("drain_rise", 32'(seen), 32'd1);
    high = 1;
    step();
    if (rtc) high++;
    en = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (!rtc) break;
      high++;
    end
    check("drain_high", high, 8);
    check("drain_idle", {rtc, busy}, 2'b00);

    // held valid while a value is pending
    en = 1'b1;
    step();
    check("hs_run", 32'(busy), 32'd1);
    inc_valid = 1'b1;
    inc = 8'd64;
    step();
    check("hs_cap1", 32'(inc_ready), 32'd0);
    lowcnt = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (inc_ready) break;
      lowcnt++;
    end
    check("hs_stall", lowcnt, 14);
    check("hs_apply_rtc", {rtc, inc_ready}, 2'b01);
    inc = 8'd32;
    step();
    check("hs_cap2", {rtc, inc_ready}, 2'b00);
    inc_valid = 1'b0;
    step();
    check("hs_inc64", {rtc, tick}, 2'b11);
    step();
    step();
    check("hs_apply2", {rtc, inc_ready}, 2'b01);
    for (int k = 1; k <= 4; k++) begin
      step();
      check($sformatf("p32_%0d", k), 32'(tick), 32'(k == 4));
    end

    en = 1'b0;
    for (int k = 0; k < 20 && busy; k++) step();
    check("stop_idle", {rtc, busy}, 2'b00);

    // inc=48: 256/48 non-integer
    inc_valid = 1'b1;
    inc = 8'd48;
    step();
    inc_valid = 1'b0;
    step();
    en = 1'b1;
    step();
    check("j_run", {rtc, busy}, 2'b01);
    t0 = nticks;
    last = -1;
    gmin = 99;
    gmax = 0;
    for (int c = 1; c <= 48; c++) begin
      step();
      if (tick) begin
        if (last >= 0) begin
          if (c - last < gmin) gmin = c - last;
          if (c - last > gmax) gmax = c - last;
        end
        last = c;
      end
    end
    check("j_ticks", nticks - t0, 9);
    check("j_gmin", gmin, 5);
    check("j_gmax", gmax, 6);

    // reset in the high phase with a pending value
    for (int k = 0; k < 20 && !rtc; k++) step();
    inc_valid = 1'b1;
    inc = 8'd64;
    step();
    check("r_pre", {rtc, inc_ready}, 2'b10);
`ifdef CLINT_RTC_GEN_TICK_CNT_EN
    check("r_cnt_pre", tick_cnt, 32'(nticks));
`endif
    rst_n = 1'b0;
    inc_valid = 1'b0;
    step();
    check("r_post", {rtc, tick, inc_ready, busy}, 4'b0010);
`ifdef CLINT_RTC_GEN_TICK_CNT_EN
    check("r_cnt_post", tick_cnt, 32'd0);
`endif
    rst_n = 1'b1;
    en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("r_stopped%0d", k), {rtc, busy}, 2'b00);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
